redundant_resolve: RTL and testbench



---
 rtl/resolve_pkg.sv | 18 +
 rtl/resolve_slice.sv | 34 +++
 rtl/redundant_resolve.sv | 115 +++++++++++
 tb/tb_redundant_resolve.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/resolve_pkg.sv
// Shared constants and types for the carry-save to canonical-digit resolver.
package resolve_pkg;

  localparam int NUM_DIGITS = 130;
  localparam int IN_W       = 19;
  localparam int DIGIT_W    = 16;
  localparam int CARRY_W    = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } resolve_state_t;

  typedef logic [NUM_DIGITS-1:0][IN_W-1:0]    in_vec_t;
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] out_vec_t;

endpackage

// File: rtl/resolve_slice.sv
// Combinational resolution of one slice of carry-save digits into radix-2^16
// digits; the carry ripples through every digit of the slice.
module resolve_slice
  import resolve_pkg::*;
#(
  parameter int DPC = 10
) (
  input  logic [DPC-1:0][IN_W-1:0]    c_in,
  input  logic [DPC-1:0][IN_W-1:0]    s_in,
  input  logic [CARRY_W-1:0]          carry_in,
  output logic [DPC-1:0][DIGIT_W-1:0] digits,
  output logic [CARRY_W-1:0]          carry_out
);

  // Two IN_W digits plus a carry need two extra bits of headroom.
  localparam int SUM_W = IN_W + 2;

  logic [SUM_W-1:0]   sum;
  logic [CARRY_W-1:0] chain;

  // Ripple the carry from the slice LSD upwards; carry never exceeds 16.
  always_comb begin
    sum    = '0;
    chain  = carry_in;
    digits = '0;
    for (int i = 0; i < DPC; i++) begin
      sum       = SUM_W'(c_in[i]) + SUM_W'(s_in[i]) + SUM_W'(chain);
      digits[i] = sum[DIGIT_W-1:0];
      chain     = CARRY_W'(sum >> DIGIT_W);
    end
    carry_out = chain;
  end

endmodule

// File: rtl/redundant_resolve.sv
// Converts a 130-digit carry-save operand into canonical 16-bit digits plus a
// top carry, resolving DIGITS_PER_CYCLE digits per clock.
module redundant_resolve
  import resolve_pkg::*;
#(
  parameter int DIGITS_PER_CYCLE = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_DIGITS-1:0][IN_W-1:0]    C,
  input  logic [NUM_DIGITS-1:0][IN_W-1:0]    S,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_DIGITS-1:0][DIGIT_W-1:0] out_digits,
  output logic [CARRY_W-1:0]                 carry_out,
  output logic                               busy
);

  localparam int NUM_SLICES = NUM_DIGITS / DIGITS_PER_CYCLE;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  if ((NUM_DIGITS % DIGITS_PER_CYCLE) != 0) begin : g_bad_dpc
    $error("DIGITS_PER_CYCLE must divide NUM_DIGITS");
  end

  resolve_state_t     state;
  logic [CNT_W-1:0]   cnt;
  logic [CARRY_W-1:0] carry_run;
  in_vec_t            op_c;
  in_vec_t            op_s;

  logic [DIGITS_PER_CYCLE-1:0][DIGIT_W-1:0] slice_d;
  logic [CARRY_W-1:0]                       slice_carry;

  logic accept;
  assign accept = (state == IDLE) && in_valid;

  // The current slice always sits in the low digits of the operand registers.
  resolve_slice #(
    .DPC(DIGITS_PER_CYCLE)
  ) u_slice (
    .c_in     (op_c[DIGITS_PER_CYCLE-1:0]),
    .s_in     (op_s[DIGITS_PER_CYCLE-1:0]),
    .carry_in (carry_run),
    .digits   (slice_d),
    .carry_out(slice_carry)
  );

  // Operand capture on accept, then shift one slice down per RESOLVE cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_c <= C;
      op_s <= S;
    end else if (state == RESOLVE) begin
      op_c <= {{DIGITS_PER_CYCLE{{IN_W{1'b0}}}}, op_c[NUM_DIGITS-1:DIGITS_PER_CYCLE]};
      op_s <= {{DIGITS_PER_CYCLE{{IN_W{1'b0}}}}, op_s[NUM_DIGITS-1:DIGITS_PER_CYCLE]};
    end
  end

  // Control FSM with registered handshake outputs and result registers.
  // Result digits enter at the top and shift down; after the last slice,
  // slice 0 has landed at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_digits <= '0;
      carry_out  <= '0;
      cnt        <= '0;
      carry_run  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry_run <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_digits <= {slice_d, out_digits[NUM_DIGITS-1:DIGITS_PER_CYCLE]};
          carry_run  <= slice_carry;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_SLICE) begin
            carry_out <= slice_carry;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_redundant_resolve.sv
// Directed and randomized bench for redundant_resolve, checked against a
// big-integer reference of the carry-save value.
module tb_redundant_resolve;
  import resolve_pkg::*;

  localparam int TW = NUM_DIGITS * DIGIT_W + CARRY_W;

  logic     clk = 1'b0;
  logic     reset;
  logic     in_valid;
  logic     in_ready;
  in_vec_t  C;
  in_vec_t  S;
  logic     out_valid;
  logic     out_ready;
  out_vec_t out_digits;
  logic [CARRY_W-1:0] carry_out;
  logic     busy;

  int tests = 0;
  int failed = 0;

  redundant_resolve #(.DIGITS_PER_CYCLE(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C         (C),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digits(out_digits),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Value of the operand as an exact integer: sum of (C[i]+S[i]) * 2^(16 i).
  function automatic logic [TW-1:0] ref_total(input in_vec_t c, input in_vec_t s);
    logic [TW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      acc = acc + ((TW'(c[i]) + TW'(s[i])) << (DIGIT_W * i));
    return acc;
  endfunction

  function automatic in_vec_t rand_vec(input int mode);
    in_vec_t v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (mode == 1) v[i] = IN_W'(19'h7FFFF - $urandom_range(0, 3));
      else if (mode == 2) v[i] = IN_W'(16'hFFFF + $urandom_range(0, 2));
      else v[i] = IN_W'($urandom());
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input out_vec_t exp);
    int bad;
    bad = 0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      if (out_digits[i] !== exp[i]) bad = i;
    tests++;
    assert (out_digits === exp) else begin
      failed++;
      $error("FAIL %s digit[%0d] observed %h expected %h", tag, bad, out_digits[bad], exp[bad]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
  endtask

  // Accept one operand, check latency and handshake, compare the result,
  // optionally stall the consumer, then release the result.
  task automatic run_op(input string tag, input in_vec_t c, input in_vec_t s,
                        input out_vec_t exp_d, input logic [CARRY_W-1:0] exp_c,
                        input int hold);
    int n;
    logic hs_ok;
    wait_ready();
    C = c;
    S = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    C = rand_vec(0);
    S = rand_vec(0);
    n = 0;
    hs_ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) hs_ok = 1'b0;
      in_valid = n[0];
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, n, 13);
    check({tag, "_busy_ready_in_resolve"}, hs_ok, 1'b1);
    check({tag, "_in_ready_done"}, in_ready, 1'b0);
    check_digits({tag, "_digits"}, exp_d);
    check({tag, "_carry"}, carry_out, exp_c);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      C = rand_vec(0);
      S = rand_vec(0);
      tick();
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
      check_digits({tag, "_hold_digits"}, exp_d);
      check({tag, "_hold_carry"}, carry_out, exp_c);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
    check_digits({tag, "_digits_retained"}, exp_d);
  endtask

  task automatic run_model(input string tag, input in_vec_t c, input in_vec_t s, input int hold);
    logic [TW-1:0] t;
    t = ref_total(c, s);
    run_op(tag, c, s, out_vec_t'(t[NUM_DIGITS*DIGIT_W-1:0]), t[TW-1 -: CARRY_W], hold);
  endtask

  initial begin
    in_vec_t  c, s, c2, s2;
    out_vec_t e;
    logic [TW-1:0] t;
    int cyc, accepts, results;
    int acc_cyc[2];
    logic acc_now;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    C = '0;
    S = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_carry", carry_out, '0);
    check_digits("rst_digits", '0);

    // All-zero operand.
    run_op("zero", '0, '0, '0, '0, 0);

    // Carry ripple across every slice boundary.
    c = '0;
    c[0] = 19'd1;
    for (int i = 0; i < NUM_DIGITS; i++) s[i] = 19'h0FFFF;
    run_op("ripple", c, s, '0, 5'd1, 0);

    // Maximum operand.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      c[i] = 19'h7FFFF;
      s[i] = 19'h7FFFF;
      e[i] = 16'h000E;
    end
    e[0] = 16'hFFFE;
    e[1] = 16'h000D;
    run_op("max", c, s, e, 5'h10, 0);

    // Back-pressure on a random operand.
    run_model("bp", rand_vec(0), rand_vec(0), 5);

    // Random operands, including near-max and carry-heavy patterns.
    run_model("rand0", rand_vec(0), rand_vec(0), 0);
    run_model("rand1", rand_vec(1), rand_vec(1), 0);
    run_model("rand2", rand_vec(2), rand_vec(0), 0);
    run_model("rand3", rand_vec(2), rand_vec(2), 1);

    // Reset while resolving slice 6.
    wait_ready();
    C = rand_vec(1);
    S = rand_vec(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_carry", carry_out, '0);
    check_digits("midrst_digits", '0);
    c = '0;
    s = '0;
    c[5] = 19'h12345;
    s[5] = 19'h0000B;
    e = '0;
    e[5] = 16'h2350;
    e[6] = 16'h0001;
    run_op("after_rst", c, s, e, '0, 0);

    // Back-to-back operands with the consumer always ready.
    c  = rand_vec(0);
    s  = rand_vec(1);
    c2 = rand_vec(2);
    s2 = rand_vec(0);
    C = c;
    S = s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    accepts = 0;
    results = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    while (cyc < 80 && results < 2) begin
      acc_now = in_ready && in_valid;
      tick();
      cyc++;
      if (acc_now) begin
        if (accepts < 2) acc_cyc[accepts] = cyc;
        accepts++;
        if (accepts == 1) begin
          C = c2;
          S = s2;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        t = (results == 0) ? ref_total(c, s) : ref_total(c2, s2);
        check_digits("b2b_digits", out_vec_t'(t[NUM_DIGITS*DIGIT_W-1:0]));
        check("b2b_carry", carry_out, t[TW-1 -: CARRY_W]);
        results++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", results, 2);
    check("b2b_accepts", accepts, 2);
    check("b2b_interval", acc_cyc[1] - acc_cyc[0], 15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
